// File: rtl/spi_write_slave.sv
// SPI mode-0 write-only slave: the first byte of a frame is a register address,
// every following byte is written to consecutive addresses as a one-cycle strobe.
module spi_write_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       CSX,
    input  logic       MOSI,
    output logic       WEN,
    output logic [7:0] WADDR,
    output logic [7:0] WDATA,
    output logic       ERR
);

    localparam int FW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, END} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] csx_sync_q, csx_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   sck_prev_q, sck_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             addr_q, addr_d;
    logic                   wen_q, wen_d;
    logic                   err_q, err_d;
    logic [7:0]             waddr_q, waddr_d;
    logic [7:0]             wdata_q, wdata_d;

    logic       sck_s, csx_s, mosi_s;
    logic       sck_rise;
    logic       primed;
    logic [7:0] byte_in;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csx_s    = csx_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign byte_in  = {shift_q[6:0], mosi_s};
    // The chains come out of reset holding idle levels, not real pin samples;
    // END must not trust csx_s until every stage has been refilled from the pin.
    assign primed   = (fill_q == FW'(SYNC_STAGES));

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        csx_sync_d  = {csx_sync_q[SYNC_STAGES-2:0], CSX};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        fill_d      = primed ? fill_q : fill_q + FW'(1);
        sck_prev_d  = sck_s;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        wen_d       = 1'b0;
        err_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                if (!csx_s) begin
                    state_d  = ADDR;
                    bitcnt_d = 3'd0;
                end
            end
            ADDR, DATA: begin
                // Deselect wins over a simultaneous SCK rise; that bit is dropped.
                if (csx_s) begin
                    state_d = IDLE;
                    err_d   = (bitcnt_q != 3'd0);
                end else if (sck_rise) begin
                    shift_d  = byte_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        bitcnt_d = 3'd0;
                        if (state_q == ADDR) begin
                            addr_d  = byte_in;
                            state_d = DATA;
                        end else begin
                            wen_d   = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = byte_in;
                            addr_d  = addr_q + 8'd1;
                        end
                    end
                end
            end
            END: begin
                if (primed && csx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = END;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_sync_q  <= '0;
            csx_sync_q  <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sck_prev_q  <= 1'b0;
            state_q     <= END;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            addr_q      <= 8'h00;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
            waddr_q     <= 8'h00;
            wdata_q     <= 8'h00;
        end else begin
            sck_sync_q  <= sck_sync_d;
            csx_sync_q  <= csx_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            err_q       <= err_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign WEN   = wen_q;
    assign ERR   = err_q;
    assign WADDR = waddr_q;
    assign WDATA = wdata_q;

endmodule

// File: tb/tb_spi_write_slave.sv
// Directed bench for spi_write_slave: a table of SPI frames with expected write
// strobes, plus hand-written sequences for mid-frame reset and same-cycle deselect.
module tb_spi_write_slave;

    localparam int HALF = 6;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SCK = 1'b0;
    logic       CSX = 1'b1;
    logic       MOSI = 1'b0;
    logic       WEN, ERR;
    logic [7:0] WADDR, WDATA;

    spi_write_slave #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .SCK(SCK), .CSX(CSX), .MOSI(MOSI),
        .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          nw;
        logic [15:0] w [3];
        logic        err;
    } vec_t;

    vec_t        vecs [7];
    int          assertions = 0;
    int          failures = 0;
    int          wen_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] wq [$];
    logic [15:0] last_w = 16'h0000;

    always @(negedge CLK) begin
        if (WEN === 1'b1) begin
            wen_cnt++;
            wq.push_back({WADDR, WDATA});
        end
        if (ERR === 1'b1) err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        MOSI = b;
        wait_clk(HALF);
        SCK = 1'b1;
        wait_clk(HALF);
        SCK = 1'b0;
    endtask

    task automatic start_frame();
        wen_cnt = 0;
        err_cnt = 0;
        wq.delete();
        CSX = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic end_frame();
        wait_clk(HALF);
        CSX = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic set_vec(input int i, input logic [31:0] bits, input int nbits, input int nw,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic err);
        vecs[i].bits  = bits;
        vecs[i].nbits = nbits;
        vecs[i].nw    = nw;
        vecs[i].w[0]  = w0;
        vecs[i].w[1]  = w1;
        vecs[i].w[2]  = w2;
        vecs[i].err   = err;
    endtask

    task automatic check_frame(input string tag, input int nw, input logic [15:0] w0,
                               input logic err);
        check({tag, "_wen_count"}, wen_cnt, nw);
        if (nw > 0 && wq.size() > 0) begin
            check({tag, "_waddr"}, {24'h0, wq[0][15:8]}, {24'h0, w0[15:8]});
            check({tag, "_wdata"}, {24'h0, wq[0][7:0]}, {24'h0, w0[7:0]});
        end
        check({tag, "_err_count"}, err_cnt, {31'h0, err});
        check({tag, "_hold_waddr"}, {24'h0, WADDR}, {24'h0, last_w[15:8]});
        check({tag, "_hold_wdata"}, {24'h0, WDATA}, {24'h0, last_w[7:0]});
        $display("%s: wen=%0d err=%0d WADDR=%02h WDATA=%02h", tag, wen_cnt, err_cnt, WADDR, WDATA);
    endtask

    initial begin
        logic [31:0] b;

        set_vec(0, 32'h01A5_0000, 16, 1, 16'h01A5, 16'h0000, 16'h0000, 1'b0);
        set_vec(1, 32'hFF11_2233, 32, 3, 16'hFF11, 16'h0022, 16'h0133, 1'b0);
        set_vec(2, 32'h10F0_0000, 12, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        set_vec(3, 32'h025A_0000, 16, 1, 16'h025A, 16'h0000, 16'h0000, 1'b0);
        set_vec(4, 32'h0000_0000,  0, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        set_vec(5, 32'hA800_0000,  5, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        set_vec(6, 32'h807E_8100, 24, 2, 16'h807E, 16'h8181, 16'h0000, 1'b0);

        wait_clk(2);
        check("reset_wen", {31'h0, WEN}, 32'h0);
        check("reset_err", {31'h0, ERR}, 32'h0);
        check("reset_waddr", {24'h0, WADDR}, 32'h0);
        check("reset_wdata", {24'h0, WDATA}, 32'h0);
        RST = 1'b0;
        wait_clk(10);

        for (int i = 0; i < 7; i++) begin
            start_frame();
            for (int k = 0; k < vecs[i].nbits; k++) send_bit(vecs[i].bits[31-k]);
            end_frame();
            check($sformatf("vec%0d_wen_count", i), wen_cnt, vecs[i].nw);
            for (int k = 0; k < vecs[i].nw && k < wq.size(); k++) begin
                check($sformatf("vec%0d_waddr%0d", i, k), {24'h0, wq[k][15:8]}, {24'h0, vecs[i].w[k][15:8]});
                check($sformatf("vec%0d_wdata%0d", i, k), {24'h0, wq[k][7:0]}, {24'h0, vecs[i].w[k][7:0]});
            end
            check($sformatf("vec%0d_err_count", i), err_cnt, {31'h0, vecs[i].err});
            if (vecs[i].nw > 0) last_w = vecs[i].w[vecs[i].nw-1];
            check($sformatf("vec%0d_hold_waddr", i), {24'h0, WADDR}, {24'h0, last_w[15:8]});
            check($sformatf("vec%0d_hold_wdata", i), {24'h0, WDATA}, {24'h0, last_w[7:0]});
            $display("vec%0d: bits=%0d wen=%0d err=%0d WADDR=%02h WDATA=%02h",
                     i, vecs[i].nbits, wen_cnt, err_cnt, WADDR, WDATA);
        end

        // Reset lands after 10 bits with CSX still low; the rest of that frame must be ignored.
        b = 32'h55C0_0000;
        start_frame();
        for (int k = 0; k < 10; k++) send_bit(b[31-k]);
        RST = 1'b1;
        wait_clk(1);
        check("midrst_wen", {31'h0, WEN}, 32'h0);
        check("midrst_err", {31'h0, ERR}, 32'h0);
        check("midrst_waddr", {24'h0, WADDR}, 32'h0);
        check("midrst_wdata", {24'h0, WDATA}, 32'h0);
        wait_clk(2);
        RST = 1'b0;
        last_w = 16'h0000;
        for (int k = 10; k < 16; k++) send_bit(b[31-k]);
        end_frame();
        check_frame("midrst_tail", 0, 16'h0000, 1'b0);

        b = 32'h00C3_0000;
        start_frame();
        for (int k = 0; k < 16; k++) send_bit(b[31-k]);
        end_frame();
        last_w = 16'h00C3;
        check_frame("post_rst", 1, 16'h00C3, 1'b0);

        // Deselect and the 8th data-bit SCK rise change together, so they sync in the same cycle.
        b = 32'h33FF_0000;
        start_frame();
        for (int k = 0; k < 15; k++) send_bit(b[31-k]);
        MOSI = 1'b1;
        wait_clk(HALF);
        SCK = 1'b1;
        CSX = 1'b1;
        wait_clk(HALF);
        SCK = 1'b0;
        wait_clk(2 * HALF);
        check_frame("csx_vs_sck", 0, 16'h0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/spi_write_slave.md
SPI_WRITE_SLAVE -- requirements
Module: spi_write_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on SCK/CSX/MOSI; legal values are 2 or more.
REQ-002 SHALL have port CLK  input  1  system clock; every flop is on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port SCK  input  1  SPI clock, asynchronous to CLK, mode 0: sample on SCK rise, MSB first.
REQ-005 SHALL have port CSX  input  1  SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port MOSI  input  1  SPI serial data in, asynchronous.
REQ-007 SHALL have port WEN  output  1  register write strobe, one CLK wide.
REQ-008 SHALL have port WADDR  output  8  write address, registered.
REQ-009 SHALL have port WDATA  output  8  write data, registered.
REQ-010 SHALL have port ERR  output  1  truncated-frame pulse, one CLK wide.

Function
REQ-011 SHALL pass SCK, CSX and MOSI each through a SYNC_STAGES-flop chain; sck_s, csx_s and mosi_s denote the chain outputs.
REQ-012 SHALL detect an SCK rise as sck_s=1 with the previous sck_s=0, and capture mosi_s in that same CLK cycle.
REQ-013 SHALL support SCK high and SCK low phases of at least SYNC_STAGES+2 CLK periods each; shorter phases are outside spec.
REQ-014 SHALL define frame format: CSX low, 8 address bits, then one or more 8-bit data bytes, then CSX high.
REQ-015 SHALL implement states IDLE, ADDR, DATA and END, with a 3-bit bit counter bitcnt.
REQ-016 SHALL transition IDLE->ADDR when csx_s=0, clearing bitcnt.
REQ-017 SHALL, in ADDR, shift one bit per SCK rise; on the 8th bit, latch the internal address, clear bitcnt and go to DATA.
REQ-018 SHALL, in DATA, shift one bit per SCK rise; on the 8th bit (cycle N), clear bitcnt and stay in DATA.
REQ-019 SHALL, in cycle N+1, drive WEN=1 with WADDR=internal address and WDATA=received byte; internal address then increments modulo 256 (0xFF->0x00).
REQ-020 SHALL hold WADDR and WDATA at their last written values until the next write; WEN is 0 in every cycle other than N+1.
REQ-021 SHALL, when csx_s=1 in ADDR or DATA, go to IDLE; ERR=1 in the next cycle if bitcnt!=0, otherwise no ERR.
REQ-022 SHALL, when a CSX deassertion and an SCK rise are seen in the same cycle, give CSX priority: the edge is ignored and the bit is discarded.
REQ-023 SHALL never produce WEN for a partial address or a partial data byte.
REQ-024 SHALL use END only to wait for csx_s=1 before going to IDLE, and ignore all SCK edges while in END.
REQ-025 SHALL allow unlimited burst length, with no limit on bytes per frame.

Reset
REQ-026 SHALL, while RST=1, force: WEN=0, ERR=0, WADDR=0x00, WDATA=0x00, internal address=0x00, bitcnt=0, state=END.
REQ-027 SHALL reset synchronizer flops to idle levels: SCK=0, CSX=1, MOSI=0.
REQ-028 SHALL, after reset release, ignore any frame already in progress: no WEN and no ERR until CSX has been seen high.

Verification
REQ-029 Single frame, CSX low, bits 0x01 then 0xA5, CSX high -> exactly one WEN pulse, WADDR=0x01, WDATA=0xA5, ERR stays 0, outputs hold afterwards.
REQ-030 Burst, address 0xFF, data 0x11,0x22,0x33 -> three WEN pulses: (0xFF,0x11), (0x00,0x22), (0x01,0x33); no ERR.
REQ-031 Truncated frame, address 0x10, then 4 data bits, then CSX high -> no WEN, ERR pulses once; a following full frame (0x02,0x5A) writes correctly.
REQ-032 CSX low, no SCK edges, CSX high -> no WEN, no ERR, state returns to IDLE.
REQ-033 RST pulse after 10 bits, CSX still low, 6 more bits clocked, then CSX high -> no WEN, no ERR; next frame (0x00,0xC3) writes once.
REQ-034 CSX rise and 8th data-bit SCK rise arrive synchronized in the same cycle -> bit discarded, no WEN, ERR pulses once.
